// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each digit and emits BCD frames over valid/ready.
// Frame valid 3 cycles after the final stable scan (+2 with SEVEN_SEG_CAPTURE_SYNC_EN); frames hold while out_ready is low.
module seven_seg_capture #(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_bcd,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    overrun
);

    localparam int CW = $clog2(STABLE_SCANS + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LW = $clog2(NUM_DIGITS + 1);

    logic [6:0]            seg_in;
    logic [NUM_DIGITS-1:0] an_in;

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
    logic [6:0]            seg_m1, seg_m2;
    logic [NUM_DIGITS-1:0] an_m1, an_m2;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m1 <= '1;
            seg_m2 <= '1;
            an_m1  <= '1;
            an_m2  <= '1;
        end else begin
            seg_m1 <= seg_n;
            seg_m2 <= seg_m1;
            an_m1  <= an_n;
            an_m2  <= an_m1;
        end
    end

    assign seg_in = seg_m2;
    assign an_in  = an_m2;
`else
    assign seg_in = seg_n;
    assign an_in  = an_n;
`endif

    // Input stage idles to "all off" so reset never looks like a scan.
    logic [6:0]            s_seg;
    logic [NUM_DIGITS-1:0] s_an;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg <= '1;
            s_an  <= '1;
        end else begin
            s_seg <= seg_in;
            s_an  <= an_in;
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = {1'b0, 4'd0};
            7'b0110000: decode = {1'b0, 4'd1};
            7'b1101101: decode = {1'b0, 4'd2};
            7'b1111001: decode = {1'b0, 4'd3};
            7'b0110011: decode = {1'b0, 4'd4};
            7'b1011011: decode = {1'b0, 4'd5};
            7'b1011111: decode = {1'b0, 4'd6};
            7'b1110000: decode = {1'b0, 4'd7};
            7'b1111111: decode = {1'b0, 4'd8};
            7'b1110011: decode = {1'b0, 4'd9};
            7'b0000000: decode = {1'b0, 4'hF};
            default:    decode = {1'b1, 4'hE};
        endcase
    endfunction

    logic [6:0]            cand [NUM_DIGITS];
    logic [CW-1:0]         cnt  [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0] err;
    logic [NUM_DIGITS-1:0] upd;
    logic                  prev_ok;
    logic [IW-1:0]         prev_idx;

    logic [LW-1:0]         low_cnt;
    logic [IW-1:0]         scan_idx;
    logic                  scan_ok;
    logic                  scan_evt;
    logic [6:0]            pat;
    logic                  cand_hit;
    logic                  cnt_sat;
    logic                  commit;
    logic [NUM_DIGITS-1:0] commit_vec;
    logic [4:0]            dec;
    logic                  frame_fire;

    always_comb begin
        low_cnt  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) begin
                low_cnt  = low_cnt + LW'(1);
                scan_idx = IW'(i);
            end
        end
    end

    // A dwell on one digit counts once; any invalid cycle breaks the dwell.
    assign scan_ok  = (low_cnt == LW'(1));
    assign scan_evt = scan_ok && !(prev_ok && (prev_idx == scan_idx));
    assign pat      = ~s_seg;
    assign cand_hit = (pat == cand[scan_idx]);
    assign cnt_sat  = (cnt[scan_idx] == CW'(STABLE_SCANS));
    assign commit   = scan_evt && (cand_hit ? (cnt[scan_idx] == CW'(STABLE_SCANS - 1))
                                            : (STABLE_SCANS == 1));
    assign dec      = decode(pat);

    always_comb begin
        commit_vec = '0;
        if (commit) commit_vec[scan_idx] = 1'b1;
    end

    assign frame_fire = (&upd) && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
            end
            dig       <= '0;
            err       <= '0;
            upd       <= '0;
            prev_ok   <= 1'b0;
            prev_idx  <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_err   <= '0;
            overrun   <= 1'b0;
        end else begin
            prev_ok  <= scan_ok;
            prev_idx <= scan_idx;

            if (scan_evt) begin
                if (cand_hit) begin
                    if (!cnt_sat) cnt[scan_idx] <= cnt[scan_idx] + CW'(1);
                end else begin
                    cand[scan_idx] <= pat;
                    cnt[scan_idx]  <= CW'(1);
                end
            end

            if (commit) begin
                dig[4*scan_idx +: 4] <= dec[3:0];
                err[scan_idx]        <= dec[4];
            end

            // A digit framed in this same cycle was not lost, so it is not an overrun.
            upd     <= (frame_fire ? '0 : upd) | commit_vec;
            overrun <= commit && upd[scan_idx] && !frame_fire;

            if (frame_fire) begin
                out_valid <= 1'b1;
                out_bcd   <= dig;
                out_err   <= err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus randomized scanning against a behavioural model.
module tb_seven_seg_capture;
    localparam int N  = 4;
    localparam int SS = 2;
`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
    localparam int DLY = 3;
`else
    localparam int DLY = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [6:0]   seg_n = '1;
    logic [N-1:0] an_n = '1;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [4*N-1:0] out_bcd;
    logic [N-1:0] out_err;
    logic         overrun;

    seven_seg_capture #(.NUM_DIGITS(N), .STABLE_SCANS(SS)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
        .out_err(out_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  passes = 0;
    bit  cmp_en = 1'b0;
    bit  rand_ready = 1'b0;
    bit  ovr_en = 1'b0;
    int  ovr_pulses = 0;
    logic [6:0] seg_tab [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [6:0] pat_of(input int d);
        if (d < 10) return seg_tab[d];
        return 7'b0000000;
    endfunction

    // Reference decoder: search the glyph table, blank is F, anything else is an error.
    function automatic logic [4:0] mdec(input logic [6:0] p);
        for (int d = 0; d < 10; d++)
            if (seg_tab[d] == p) return {1'b0, 4'(d)};
        if (p == 7'b0) return {1'b0, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    logic [6:0]   hs [DLY];
    logic [N-1:0] ha [DLY];
    logic [6:0]   mcand [N];
    int           mcnt  [N];
    logic [3:0]   mdig  [N];
    bit           merr  [N];
    bit           mupd  [N];
    bit           m_pok;
    int           m_pidx;
    bit           m_valid;
    logic [4*N-1:0] m_bcd;
    logic [N-1:0] m_err;
    bit           m_ovr;

    always @(posedge clk) begin : model
        logic [6:0]   cs;
        logic [6:0]   p;
        logic [N-1:0] ca;
        logic [4:0]   d;
        int  z, idx;
        bit  evt, commit, fire, allu, ovr_n;
        if (rst) begin
            for (int k = 0; k < DLY; k++) begin hs[k] = '1; ha[k] = '1; end
            for (int k = 0; k < N; k++) begin
                mcand[k] = '0; mcnt[k] = 0; mdig[k] = '0; merr[k] = 0; mupd[k] = 0;
            end
            m_pok = 0; m_pidx = 0; m_valid = 0; m_bcd = '0; m_err = '0; m_ovr = 0;
        end else begin
            cs = hs[DLY-1];
            ca = ha[DLY-1];
            for (int k = DLY - 1; k > 0; k--) begin hs[k] = hs[k-1]; ha[k] = ha[k-1]; end
            hs[0] = seg_n;
            ha[0] = an_n;
            z = 0; idx = 0;
            for (int k = 0; k < N; k++) if (!ca[k]) begin z++; idx = k; end
            evt = (z == 1) && !(m_pok && m_pidx == idx);
            commit = 0;
            p = ~cs;
            if (evt) begin
                if (p == mcand[idx]) begin
                    if (mcnt[idx] < SS) begin
                        mcnt[idx]++;
                        commit = (mcnt[idx] == SS);
                    end
                end else begin
                    mcand[idx] = p;
                    mcnt[idx]  = 1;
                    commit = (SS == 1);
                end
            end
            allu = 1;
            for (int k = 0; k < N; k++) if (!mupd[k]) allu = 0;
            fire  = allu && (!m_valid || out_ready);
            ovr_n = commit && mupd[idx] && !fire;
            if (fire) begin
                for (int k = 0; k < N; k++) begin
                    m_bcd[4*k +: 4] = mdig[k];
                    m_err[k] = merr[k];
                    mupd[k] = 0;
                end
                m_valid = 1;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (commit) begin
                d = mdec(p);
                mdig[idx] = d[3:0];
                merr[idx] = d[4];
                mupd[idx] = 1;
            end
            m_ovr  = ovr_n;
            m_pok  = (z == 1);
            m_pidx = idx;
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            check("cycle", {10'b0, out_valid, out_bcd, out_err, overrun},
                           {10'b0, m_valid, m_bcd, m_err, m_ovr});
        if (ovr_en && overrun === 1'b1) ovr_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic show(input int i, input logic [6:0] p, input int dwell);
        logic [N-1:0] sel;
        sel = '0;
        sel[i] = 1'b1;
        an_n  = ~sel;
        seg_n = ~p;
        repeat (dwell) tick();
    endtask

    task automatic refresh(input logic [6:0] p0, input logic [6:0] p1,
                           input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 4); show(1, p1, 4); show(2, p2, 4); show(3, p3, 4);
    endtask

    task automatic idle(input int n);
        an_n = '1;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] mdl,
                       input logic [31:0] exp);
        @(negedge clk);
        check(name, got, exp);
        check({name, "_model"}, mdl, exp);
    endtask

    initial begin
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1110011;

        do_reset();
        cmp_en = 1'b1;
        pin("reset_state", {out_valid, out_bcd, out_err, overrun}, {m_valid, m_bcd, m_err, m_ovr}, 0);

        // Basic frame
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        pin("t1_valid", out_valid, m_valid, 1);
        pin("t1_bcd", out_bcd, m_bcd, 32'h4321);
        pin("t1_err", out_err, m_err, 0);
        out_ready = 1'b1;
        idle(2);
        pin("t1_drop", out_valid, m_valid, 0);
        out_ready = 1'b0;

        // Flickering digit never commits
        do_reset();
        for (int k = 0; k < 4; k++)
            refresh(pat_of(1), pat_of(2), pat_of((k % 2) ? 6 : 5), pat_of(4));
        idle(4);
        pin("t2_noframe", out_valid, m_valid, 0);
        refresh(pat_of(1), pat_of(2), pat_of(5), pat_of(5 - 1));
        refresh(pat_of(1), pat_of(2), pat_of(5), pat_of(4));
        idle(4);
        pin("t2_bcd", out_bcd, m_bcd, 32'h4521);

        // Illegal and blank patterns
        do_reset();
        refresh(7'b1000000, pat_of(2), pat_of(3), pat_of(4));
        refresh(7'b1000000, pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        pin("t3_bcd_ill", out_bcd, m_bcd, 32'h432E);
        pin("t3_err_ill", out_err, m_err, 32'h1);
        do_reset();
        refresh(7'b0, pat_of(2), pat_of(3), pat_of(4));
        refresh(7'b0, pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        pin("t3_bcd_blank", out_bcd, m_bcd, 32'h432F);
        pin("t3_err_blank", out_err, m_err, 0);

        // Backpressure with re-commits
        do_reset();
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        ovr_pulses = 0;
        ovr_en = 1'b1;
        refresh(pat_of(5), pat_of(6), pat_of(7), pat_of(8));
        refresh(pat_of(5), pat_of(6), pat_of(7), pat_of(8));
        refresh(pat_of(9), pat_of(0), pat_of(1), pat_of(2));
        refresh(pat_of(9), pat_of(0), pat_of(1), pat_of(2));
        idle(4);
        ovr_en = 1'b0;
        check("t4_overruns", ovr_pulses, 4);
        pin("t4_held", out_bcd, m_bcd, 32'h4321);
        out_ready = 1'b1;
        tick();
        pin("t4_newest", out_bcd, m_bcd, 32'h2109);
        tick();
        pin("t4_drained", out_valid, m_valid, 0);
        out_ready = 1'b0;

        // Invalid enables mid-scan
        do_reset();
        show(0, pat_of(1), 4);
        show(1, pat_of(2), 4);
        an_n = '0; repeat (10) tick();
        an_n = '1; repeat (10) tick();
        show(2, pat_of(3), 4);
        show(3, pat_of(4), 4);
        idle(4);
        pin("t5_noframe", out_valid, m_valid, 0);
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        pin("t5_frame", out_bcd, m_bcd, 32'h4321);

        // Reset with a frame pending and partial updates
        show(0, pat_of(5), 4); show(1, pat_of(6), 4);
        show(0, pat_of(5), 4); show(1, pat_of(6), 4);
        idle(1);
        rst = 1'b1;
        tick();
        pin("t6_rst_outs", {out_valid, out_bcd, out_err, overrun}, {m_valid, m_bcd, m_err, m_ovr}, 0);
        rst = 1'b0;
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        pin("t6_noframe", out_valid, m_valid, 0);
        refresh(pat_of(1), pat_of(2), pat_of(3), pat_of(4));
        idle(4);
        pin("t6_frame", out_bcd, m_bcd, 32'h4321);

        // Randomized scanning, checked every cycle by the model
        rand_ready = 1'b1;
        for (int it = 0; it < 150; it++) begin
            logic [6:0] rp [N];
            for (int k = 0; k < N; k++) begin
                int v;
                v = $urandom_range(0, 12);
                rp[k] = (v < 10) ? pat_of(v) : (v == 10) ? 7'b0 : 7'($urandom);
            end
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) begin
                for (int k = 0; k < N; k++) begin
                    if ($urandom_range(0, 9) != 0) show(k, rp[k], $urandom_range(1, 4));
                    if ($urandom_range(0, 15) == 0) begin
                        an_n = N'($urandom);
                        repeat ($urandom_range(1, 3)) tick();
                    end
                end
            end
            if ($urandom_range(0, 39) == 0) do_reset();
        end
        rand_ready = 1'b0;
        idle(8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
